// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with optional mem_ready handshake.
// Define MCC_PERF_CNT_EN to build the instruction/cycle performance counters.
module multicycle_control #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JAL       = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11,
        JR        = 4'd12,
        ILLEGAL   = 4'd13
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic       illegal;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_FETCH = '{
        mem_req: 1'b1, fetch: 1'b1, mem_read: 1'b1,
        alu_src_b: 2'b01, default: '0
    };

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   rdy;
    logic   op_mem, op_jr, op_r, op_beq, op_imm, op_jal;

    assign rdy    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign op_mem = (opcode == 6'b100011) || (opcode == 6'b101011);
    assign op_jr  = (opcode == 6'b000000) && (funct == 6'b001000);
    assign op_r   = (opcode == 6'b000000) && (funct != 6'b001000);
    assign op_beq = (opcode == 6'b000100);
    assign op_imm = (opcode == 6'b001000) || (opcode == 6'b001100);
    assign op_jal = (opcode == 6'b000011);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     state_d = rdy ? DECODE : FETCH;
            DECODE: begin
                unique case (1'b1)
                    op_mem:  state_d = MEM_ADDR;
                    op_jr:   state_d = JR;
                    op_r:    state_d = R_EXEC;
                    op_beq:  state_d = BRANCH;
                    op_imm:  state_d = I_EXEC;
                    op_jal:  state_d = JAL;
                    default: state_d = ILLEGAL;
                endcase
            end
            MEM_ADDR:  state_d = opcode[3] ? MEM_WRITE : MEM_READ;
            MEM_READ:  state_d = rdy ? MEM_WB : MEM_READ;
            MEM_WRITE: state_d = rdy ? FETCH : MEM_WRITE;
            R_EXEC:    state_d = R_WB;
            I_EXEC:    state_d = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JAL, JR: state_d = FETCH;
            default:   state_d = ILLEGAL;
        endcase
    end

    // Outputs are decoded from the next state so they come out of flops.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            FETCH:  ctrl_d = CTRL_FETCH;
            DECODE: ctrl_d.alu_src_b = 2'b11;
            MEM_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            MEM_READ: begin
                ctrl_d.mem_req  = 1'b1;
                ctrl_d.mem_read = 1'b1;
                ctrl_d.iord     = 1'b1;
            end
            MEM_WRITE: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.iord      = 1'b1;
            end
            MEM_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 2'b01;
            end
            R_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b10;
            end
            R_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 2'b01;
            end
            I_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                ctrl_d.alu_op    = (opcode == 6'b001100) ? 2'b11 : 2'b00;
            end
            I_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ctrl_q.alu_op;
            end
            BRANCH: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_op        = 2'b01;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_source     = 2'b01;
            end
            JAL: begin
                ctrl_d.pc_write   = 1'b1;
                ctrl_d.pc_source  = 2'b10;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dst    = 2'b10;
                ctrl_d.mem_to_reg = 2'b10;
            end
            JR: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = 2'b11;
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            ctrl_q  <= CTRL_FETCH;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // The fetch strobes fire in the completing cycle, never while in reset.
    assign ir_write      = ctrl_q.fetch & rdy & reset_n;
    assign pc_write      = ctrl_q.pc_write | ir_write;
    assign mem_req       = ctrl_q.mem_req;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign iord          = ctrl_q.iord;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign pc_source     = ctrl_q.pc_source;
    assign illegal_op    = ctrl_q.illegal;
    assign state         = state_q;

`ifdef MCC_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;
    logic             retire;

    assign retire = (state_d == FETCH) && (state_q != FETCH);

    always_comb begin
        cyc_d = cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
        ins_d = ins_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule
